// File: rtl/serializer_par_to_ser.sv
// serializer_par_to_ser
// Parametrised DATA_W-to-OUT_W serializer. Words arrive over valid/ready,
// leave as N = DATA_W/OUT_W registered chunks on dout. A one-word holding
// buffer lets the next word be taken mid-word so streaming stays gapless.
// word_start/word_last mark word boundaries; underrun pulses once when the
// stream stops after a last beat with no next word available.

module serializer_par_to_ser #(
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_valid,
    output logic              word_start,
    output logic              word_last,
    output logic              underrun
);

    localparam int N     = DATA_W / OUT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Chunk that goes out first from a word, in the configured order.
    function automatic logic [OUT_W-1:0] head(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w[DATA_W-1 -: OUT_W];
        else           return w[OUT_W-1:0];
    endfunction

    // Word with its first chunk consumed, so the next chunk becomes the head.
    function automatic logic [DATA_W-1:0] tail(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w << OUT_W;
        else           return w >> OUT_W;
    endfunction

    logic [DATA_W-1:0] r_shift;      // remaining chunks of the word on dout
    logic [DATA_W-1:0] r_hold;       // next word, taken while the shifter is busy
    logic              r_hold_full;
    logic [CNT_W-1:0]  r_cnt;        // index of the chunk currently on dout
    logic [OUT_W-1:0]  r_dout;
    logic              r_dout_valid;
    logic              r_word_start;
    logic              r_word_last;
    logic              r_underrun;

    logic              w_xfer;
    logic              w_load_due;
    logic              w_has_src;
    logic [DATA_W-1:0] w_src_word;

    // The held word has priority; while it exists s_ready is low, so a
    // same-cycle transfer cannot compete with it.
    assign s_ready    = ~r_hold_full;
    assign w_xfer     = s_valid & ~r_hold_full;
    assign w_load_due = ~r_dout_valid | (r_cnt == LAST_BEAT);
    assign w_has_src  = r_hold_full | w_xfer;
    assign w_src_word = r_hold_full ? r_hold : s_data;

    // Control and output registers: load a new word, advance a beat, or go idle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            r_hold_full  <= 1'b0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_word_start <= 1'b0;
            r_word_last  <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (w_load_due) begin
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            if (w_has_src) begin
                r_dout       <= head(w_src_word);
                r_dout_valid <= 1'b1;
                r_word_start <= 1'b1;
                r_word_last  <= (N == 1);
                r_underrun   <= 1'b0;
            end else begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
                r_word_start <= 1'b0;
                r_word_last  <= 1'b0;
                r_underrun   <= r_dout_valid;
            end
        end else begin
            r_cnt        <= r_cnt + CNT_ONE;
            r_dout       <= head(r_shift);
            r_word_start <= 1'b0;
            r_word_last  <= ((r_cnt + CNT_ONE) == LAST_BEAT);
            r_underrun   <= 1'b0;
            if (w_xfer) r_hold_full <= 1'b1;
        end
    end

    // Datapath registers: shifter contents and the held word.
    always_ff @(posedge clk) begin
        // NOTE: no reset on these data registers; r_dout_valid and
        // r_hold_full already mark their contents as meaningless after reset.
        if (w_load_due) begin
            if (w_has_src) r_shift <= tail(w_src_word);
        end else begin
            r_shift <= tail(r_shift);
            if (w_xfer) r_hold <= s_data;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign word_start = r_word_start;
    assign word_last  = r_word_last;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_serializer_par_to_ser.sv
// tb_serializer_par_to_ser
// Three serializer configurations: 16->1 MSB-first, 16->4 LSB-first and
// 16->16. Inputs change on the falling edge; outputs are compared on the
// falling edge just before the next inputs are driven.

module tb_serializer_par_to_ser;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        e_rdy;
        logic [15:0] e_dout;
        logic        e_dv;
        logic        e_ws;
        logic        e_wl;
        logic        e_ur;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [15:0] s_data0, s_data1, s_data2;
    logic        s_valid0, s_valid1, s_valid2;
    logic        s_ready0, s_ready1, s_ready2;
    logic [0:0]  dout0;
    logic [3:0]  dout1;
    logic [15:0] dout2;
    logic        dv0, dv1, dv2, ws0, ws1, ws2, wl0, wl1, wl2, ur0, ur1, ur2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serializer_par_to_ser #(.DATA_W(16), .OUT_W(1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data0), .s_valid(s_valid0),
        .s_ready(s_ready0), .dout(dout0), .dout_valid(dv0),
        .word_start(ws0), .word_last(wl0), .underrun(ur0));

    serializer_par_to_ser #(.DATA_W(16), .OUT_W(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .dout(dout1), .dout_valid(dv1),
        .word_start(ws1), .word_last(wl1), .underrun(ur1));

    serializer_par_to_ser #(.DATA_W(16), .OUT_W(16), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2),
        .s_ready(s_ready2), .dout(dout2), .dout_valid(dv2),
        .word_start(ws2), .word_last(wl2), .underrun(ur2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {rdy,dv,ws,wl,ur,dout}=%h, expected %h", name, act, exp);
        end
    endtask

    // Compare the selected DUT's outputs at the falling edge, then drive its inputs.
    task automatic step(input int sel, input vec_t vec, input string name);
        logic [31:0] act;
        logic [31:0] exp;
        @(negedge clk);
        case (sel)
            0:       act = {11'd0, s_ready0, dv0, ws0, wl0, ur0, 15'd0, dout0};
            1:       act = {11'd0, s_ready1, dv1, ws1, wl1, ur1, 12'd0, dout1};
            default: act = {11'd0, s_ready2, dv2, ws2, wl2, ur2, dout2};
        endcase
        exp = {11'd0, vec.e_rdy, vec.e_dv, vec.e_ws, vec.e_wl, vec.e_ur, vec.e_dout};
        check(name, act, exp);
        case (sel)
            0:       begin s_valid0 = vec.v; s_data0 = vec.d; end
            1:       begin s_valid1 = vec.v; s_data1 = vec.d; end
            default: begin s_valid2 = vec.v; s_data2 = vec.d; end
        endcase
    endtask

    // Gapless three-word stream on u0 with a tiny hold-buffer model for s_ready.
    // offer[i] is the earliest cycle at which word i is presented.
    task automatic stream3(input logic [15:0] words[3], input int offer[3], input string name);
        int   src = 0;
        logic m_hold = 1'b0;
        for (int c = 0; c <= 49; c++) begin
            vec_t vv;
            int   w = (c - 1) / 16;
            int   k = (c - 1) % 16;
            logic acc;
            logic load_due;
            vv.v = (src < 3) && (c >= offer[src]);
            vv.d = (src < 3) ? words[src] : 16'h0;
            vv.e_rdy = ~m_hold;
            if (c >= 1 && c <= 48) begin
                logic [15:0] ww = words[w];
                vv.e_dout = {15'd0, ww[15-k]};
                vv.e_dv = 1'b1; vv.e_ws = (k == 0); vv.e_wl = (k == 15); vv.e_ur = 1'b0;
            end else begin
                vv.e_dout = 16'h0; vv.e_dv = 1'b0; vv.e_ws = 1'b0; vv.e_wl = 1'b0;
                vv.e_ur = (c == 49);
            end
            step(0, vv, name);
            acc      = vv.v && vv.e_rdy;
            load_due = (c == 0) || (c >= 48) || (k == 15);
            if (load_due)  m_hold = 1'b0;
            else if (acc)  m_hold = 1'b1;
            if (acc) src++;
        end
    endtask

    localparam vec_t IDLE = '{1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    vec_t        t3[17];
    vec_t        t4[11];
    logic [15:0] w4[8];
    logic [15:0] wa[3];
    int          oa[3];

    initial begin
        // 16->4 LSB-first: 1234 alone (underrun), then BEEF with 0F5A held behind it.
        t3[0]  = '{1'b1, 16'h1234, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        t3[1]  = '{1'b0, 16'h0,    1'b1, 16'h4, 1'b1, 1'b1, 1'b0, 1'b0};
        t3[2]  = '{1'b0, 16'h0,    1'b1, 16'h3, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[3]  = '{1'b0, 16'h0,    1'b1, 16'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[4]  = '{1'b0, 16'h0,    1'b1, 16'h1, 1'b1, 1'b0, 1'b1, 1'b0};
        t3[5]  = '{1'b0, 16'h0,    1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        t3[6]  = '{1'b1, 16'hBEEF, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        t3[7]  = '{1'b1, 16'h0F5A, 1'b1, 16'hF, 1'b1, 1'b1, 1'b0, 1'b0};
        t3[8]  = '{1'b0, 16'h0,    1'b0, 16'hE, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[9]  = '{1'b0, 16'h0,    1'b0, 16'hE, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[10] = '{1'b0, 16'h0,    1'b0, 16'hB, 1'b1, 1'b0, 1'b1, 1'b0};
        t3[11] = '{1'b0, 16'h0,    1'b1, 16'hA, 1'b1, 1'b1, 1'b0, 1'b0};
        t3[12] = '{1'b0, 16'h0,    1'b1, 16'h5, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[13] = '{1'b0, 16'h0,    1'b1, 16'hF, 1'b1, 1'b0, 1'b0, 1'b0};
        t3[14] = '{1'b0, 16'h0,    1'b1, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        t3[15] = '{1'b0, 16'h0,    1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        t3[16] = IDLE;

        // 16->16: one word per clock straight through, then underrun.
        w4 = '{16'hDEAD, 16'hBEEF, 16'h0000, 16'hFFFF, 16'h1234, 16'h8001, 16'h5A5A, 16'hC3C3};
        t4[0] = '{1'b1, w4[0], 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i < 8; i++)
            t4[i] = '{1'b1, w4[i], 1'b1, w4[i-1], 1'b1, 1'b1, 1'b1, 1'b0};
        t4[8]  = '{1'b0, 16'h0, 1'b1, w4[7], 1'b1, 1'b1, 1'b1, 1'b0};
        t4[9]  = '{1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        t4[10] = IDLE;

        rst_n = 1'b0;
        s_valid0 = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;
        s_data0 = 16'h0; s_data1 = 16'h0; s_data2 = 16'h0;
        repeat (2) @(posedge clk);
        step(0, IDLE, "reset_u0");
        step(1, IDLE, "reset_u1");
        step(2, IDLE, "reset_u2");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) step(1, t3[i], $sformatf("t3_vec%0d", i));
        for (int i = 0; i < 11; i++) step(2, t4[i], $sformatf("t4_vec%0d", i));

        // T1: A5C3 MSB-first, then underrun and idle.
        begin
            logic [15:0] wd = 16'hA5C3;
            vec_t vv;
            step(0, '{1'b1, wd, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "t1_accept");
            for (int k = 0; k < 16; k++) begin
                vv = '{1'b0, 16'h0, 1'b1, {15'd0, wd[15-k]}, 1'b1, (k == 0), (k == 15), 1'b0};
                step(0, vv, $sformatf("t1_beat%0d", k));
            end
            step(0, '{1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}, "t1_underrun");
            step(0, IDLE, "t1_idle");
        end

        // T2: source always ready with the next word.
        wa = '{16'hFFFF, 16'h0000, 16'h1234};
        oa = '{0, 0, 0};
        stream3(wa, oa, "t2_stream");
        step(0, IDLE, "t2_idle");

        // T5: second word offered at beat 3, third at beat 4.
        wa = '{16'hC0DE, 16'h1357, 16'h2468};
        oa = '{0, 4, 5};
        stream3(wa, oa, "t5_stream");
        step(0, IDLE, "t5_idle");

        // T6: reset at beat 7 while a word is held; it must never appear.
        begin
            logic [15:0] wd = 16'hF0F0;
            vec_t vv;
            step(0, '{1'b1, wd, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "t6_accept");
            for (int k = 0; k < 8; k++) begin
                vv = '{(k == 0), 16'hFFFF, (k == 0), {15'd0, wd[15-k]}, 1'b1, (k == 0), 1'b0, 1'b0};
                step(0, vv, $sformatf("t6_beat%0d", k));
            end
            rst_n = 1'b0;
            step(0, IDLE, "t6_in_reset");
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) step(0, IDLE, $sformatf("t6_after%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
